// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if
//   Bundles the writeback-stage request, the auxiliary producer handshake
//   and the register-file write port of regfile_write_arbiter.
//
//   master : the side that drives writeback/auxiliary requests and receives
//            aux_ready, stall_w and the rf_* write port.
//   slave  : the arbiter itself.
//
//   Signals
//     pipe_we_w / pipe_wa_w / pipe_wd_w : writeback enable, address, data
//     aux_valid / aux_wa / aux_wd       : auxiliary result offer
//     aux_ready                         : auxiliary FIFO can accept this cycle
//     stall_w                           : writeback must hold its inputs
//     rf_we / rf_wa / rf_wd             : register-file write port
interface regfile_write_arbiter_if;
    logic        pipe_we_w;
    logic [4:0]  pipe_wa_w;
    logic [31:0] pipe_wd_w;
    logic        aux_valid;
    logic [4:0]  aux_wa;
    logic [31:0] aux_wd;
    logic        aux_ready;
    logic        stall_w;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    modport master (
        output pipe_we_w, pipe_wa_w, pipe_wd_w,
        output aux_valid, aux_wa, aux_wd,
        input  aux_ready, stall_w,
        input  rf_we, rf_wa, rf_wd
    );

    modport slave (
        input  pipe_we_w, pipe_wa_w, pipe_wd_w,
        input  aux_valid, aux_wa, aux_wd,
        output aux_ready, stall_w,
        output rf_we, rf_wa, rf_wd
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the single register-file write port between the writeback stage
//   and one auxiliary multi-cycle producer. Auxiliary results wait in an
//   in-order FIFO and are written in cycles writeback leaves free. A queued
//   result is squashed when a younger writeback targets the same register.
//
//   Optional feature (macro RF_ARB_STARVE_GUARD_EN): a starvation counter
//   that raises stall_w for one cycle once a valid FIFO head has waited
//   STARVE_LIMIT cycles, letting the head drain. Without the macro stall_w
//   is tied low and queued entries drain only in pipe-idle cycles.
//
//   Parameters
//     DEPTH        : FIFO entries, power of two, >= 2
//     STARVE_LIMIT : cycles a valid head may wait before stall, >= 1
//
//   Ports
//     clk   : clock, all state updates on the rising edge
//     reset : asynchronous, active-high reset; empties the FIFO
//     bus   : regfile_write_arbiter_if.slave (writeback, aux, rf port)
module regfile_write_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    regfile_write_arbiter_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("regfile_write_arbiter: DEPTH must be a power of two >= 2");
    end
    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("regfile_write_arbiter: STARVE_LIMIT must be >= 1");
    end

    // FIFO storage; count includes squashed slots still awaiting their pop.
    logic [DEPTH-1:0] ent_valid;
    logic [4:0]       ent_wa [DEPTH];
    logic [31:0]      ent_wd [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;

    logic pipe_req;
    logic head_present;
    logic head_valid;
    logic push;
    logic store;
    logic pop;
    logic stall;

    // aux_ready looks only at current occupancy, never at a same-cycle pop.
    assign bus.aux_ready = (count < CW'(DEPTH)) & ~reset;
    assign push          = bus.aux_valid & bus.aux_ready;
    // A push to r0 is accepted but never occupies a slot.
    assign store         = push & (bus.aux_wa != 5'd0);

    assign head_present  = (count != '0);
    assign head_valid    = head_present & ent_valid[rd_ptr];

    assign pipe_req = bus.pipe_we_w & (bus.pipe_wa_w != 5'd0) & ~stall & ~reset;
    // A squashed head leaves in any cycle; a valid head only when it wins.
    assign pop      = head_present & ~reset & (~head_valid | ~pipe_req);

    // Write-port grant: writeback first, then a valid FIFO head.
    always_comb begin
        // NOTE: every output gets a default before the branches so no
        // path leaves a value held, which would otherwise infer a latch.
        bus.rf_we = 1'b0;
        bus.rf_wa = 5'd0;
        bus.rf_wd = 32'd0;
        if (pipe_req) begin
            bus.rf_we = 1'b1;
            bus.rf_wa = bus.pipe_wa_w;
            bus.rf_wd = bus.pipe_wd_w;
        end else if (head_valid) begin
            bus.rf_we = 1'b1;
            bus.rf_wa = ent_wa[rd_ptr];
            bus.rf_wd = ent_wd[rd_ptr];
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (store) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(store) - CW'(pop);
        end
    end

    // Entry storage and squash.
    // NOTE: the storage arrays carry no reset; an empty FIFO (count == 0)
    // already makes their contents irrelevant, and reset-free memories
    // map onto plain RAM/flop arrays without a reset tree.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (pipe_req && ent_wa[i] == bus.pipe_wa_w)
                ent_valid[i] <= 1'b0;
        end
        // Written after the squash loop so a same-cycle push stays valid.
        if (store) begin
            ent_valid[wr_ptr] <= 1'b1;
            ent_wa[wr_ptr]    <= bus.aux_wa;
            ent_wd[wr_ptr]    <= bus.aux_wd;
        end
    end

`ifdef RF_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_cnt;

    // Counts cycles a valid head waits; saturates at STARVE_LIMIT, where
    // the resulting stall forces a pop that clears it again.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!head_present || pop) begin
            starve_cnt <= '0;
        end else if (head_valid && starve_cnt != SW'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign stall = (starve_cnt == SW'(STARVE_LIMIT));
`else
    assign stall = 1'b0;
`endif

    assign bus.stall_w = stall;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
//   Directed bench with a scoreboard: every expected register-file write is
//   queued when its stimulus is planned, and a negedge monitor pops and
//   compares each write the DUT presents. Cycle-specific properties
//   (aux_ready, stall_w, idle write port) are checked directly.
//   Expectations follow RF_ARB_STARVE_GUARD_EN when it is defined.
module tb_regfile_write_arbiter;
    typedef struct packed {
        logic [4:0]  wa;
        logic [31:0] wd;
    } wr_t;

    logic clk;
    logic reset;
    regfile_write_arbiter_if bus ();

    regfile_write_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    wr_t exp_q[$];
    logic [31:0] shadow [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic expect_wr(input logic [4:0] wa, input logic [31:0] wd);
        wr_t e;
        e.wa = wa;
        e.wd = wd;
        exp_q.push_back(e);
    endtask

    task automatic apply(input logic pwe, input logic [4:0] pwa, input logic [31:0] pwd,
                         input logic av, input logic [4:0] awa, input logic [31:0] awd);
        bus.pipe_we_w = pwe;
        bus.pipe_wa_w = pwa;
        bus.pipe_wd_w = pwd;
        bus.aux_valid = av;
        bus.aux_wa    = awa;
        bus.aux_wd    = awd;
        #1;
    endtask

    task automatic idle();
        apply(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: any write the DUT presents must be the next expected one.
    always @(negedge clk) begin
        if (bus.rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got write r%0d=0x%0h expected no write at %0t",
                         bus.rf_wa, bus.rf_wd, $time);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("sb_wa", 32'(bus.rf_wa), 32'(e.wa));
                check("sb_wd", bus.rf_wd, e.wd);
            end
            shadow[bus.rf_wa] = bus.rf_wd;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int cyc;
        int stall_at;
        int stalls;

        // Reset with the pipe requesting: the write port must stay idle.
        reset = 1'b1;
        apply(1'b1, 5'd7, 32'h77, 1'b1, 5'd8, 32'h88);
        check("rst_rf_we", 32'(bus.rf_we), 32'd0);
        check("rst_aux_ready", 32'(bus.aux_ready), 32'd0);
        check("rst_stall", 32'(bus.stall_w), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        idle();
        check("post_rst_aux_ready", 32'(bus.aux_ready), 32'd1);
        tick();

        // 1: single aux push with idle pipe, written the following cycle.
        expect_wr(5'd3, 32'h11);
        apply(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h11);
        check("t1_ready_push", 32'(bus.aux_ready), 32'd1);
        tick();
        idle();
        check("t1_rf_we", 32'(bus.rf_we), 32'd1);
        check("t1_rf_wa", 32'(bus.rf_wa), 32'd3);
        check("t1_rf_wd", bus.rf_wd, 32'h11);
        check("t1_ready_after", 32'(bus.aux_ready), 32'd1);
        tick();

        // 2: fill the FIFO while the pipe writes r1 every cycle.
`ifdef RF_ARB_STARVE_GUARD_EN
        for (int i = 0; i < 9; i++) expect_wr(5'd1, 32'h200 + i);
        expect_wr(5'd10, 32'h100);
        expect_wr(5'd1, 32'h209);
        for (int i = 1; i < 4; i++) expect_wr(5'(10 + i), 32'h100 + i);
`else
        for (int i = 0; i < 10; i++) expect_wr(5'd1, 32'h200 + i);
        for (int i = 0; i < 4; i++) expect_wr(5'(10 + i), 32'h100 + i);
`endif
        k = 0;
        cyc = 0;
        stall_at = -1;
        while (k < 10 && cyc < 40) begin
            apply(1'b1, 5'd1, 32'h200 + k, cyc < 4, 5'(10 + cyc), 32'h100 + cyc);
            if (cyc == 4) check("t2_full_ready", 32'(bus.aux_ready), 32'd0);
            if (bus.stall_w) begin
                if (stall_at < 0) stall_at = cyc;
            end else begin
                k++;
            end
            tick();
            cyc++;
        end
`ifdef RF_ARB_STARVE_GUARD_EN
        check("t2_stall_cycle", 32'(stall_at), 32'd9);
`else
        check("t2_stall_cycle", 32'(stall_at), 32'hFFFF_FFFF);
`endif
        idle();
        for (int i = 0; i < 6; i++) tick();

        // 3: queued r5 squashed by a younger pipe write to r5.
        expect_wr(5'd5, 32'hBB);
        apply(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hAA);
        tick();
        apply(1'b1, 5'd5, 32'hBB, 1'b0, 5'd0, 32'd0);
        tick();
        idle();
        check("t3_squash_pop_no_write", 32'(bus.rf_we), 32'd0);
        tick();
        tick();
        check("t3_r5_final", shadow[5], 32'hBB);

        // 4: pushes to r0 are accepted but never occupy the FIFO.
        for (int i = 0; i < 4; i++) expect_wr(5'd2, 32'h400 + i);
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 5'd2, 32'h400 + i, 1'b1, 5'd0, 32'hFF);
            check("t4_ready", 32'(bus.aux_ready), 32'd1);
            tick();
        end
        idle();
        check("t4_no_write", 32'(bus.rf_we), 32'd0);
        tick();

        // 5: reset mid-operation with three entries queued.
        for (int i = 0; i < 3; i++) expect_wr(5'd4, 32'h500 + i);
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 5'd4, 32'h500 + i, 1'b1, 5'(20 + i), 32'h5A0 + i);
            tick();
        end
        reset = 1'b1;
        apply(1'b1, 5'd4, 32'h5FF, 1'b0, 5'd0, 32'd0);
        check("t5_rst_rf_we", 32'(bus.rf_we), 32'd0);
        check("t5_rst_aux_ready", 32'(bus.aux_ready), 32'd0);
        check("t5_rst_stall", 32'(bus.stall_w), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        idle();
        check("t5_ready_after", 32'(bus.aux_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            idle();
            check("t5_no_stale", 32'(bus.rf_we), 32'd0);
            tick();
        end

`ifndef RF_ARB_STARVE_GUARD_EN
        // 6: no guard; a queued entry waits out 20 pipe writes.
        for (int i = 0; i < 20; i++) expect_wr(5'd6, 32'h600 + i);
        expect_wr(5'd9, 32'h99);
        stalls = 0;
        for (int i = 0; i < 20; i++) begin
            apply(1'b1, 5'd6, 32'h600 + i, i == 0, 5'd9, 32'h99);
            if (bus.stall_w) stalls++;
            tick();
        end
        check("t6_stalls", 32'(stalls), 32'd0);
        idle();
        check("t6_rf_we", 32'(bus.rf_we), 32'd1);
        check("t6_rf_wa", 32'(bus.rf_wa), 32'd9);
        check("t6_rf_wd", bus.rf_wd, 32'h99);
        tick();
`endif

        idle();
        for (int i = 0; i < 4; i++) tick();
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

- Shares the single register-file write port between the pipeline's writeback stage and one auxiliary multi-cycle producer, such as a divider or a slow load return.
- Auxiliary results are queued in an in-order FIFO and written in cycles where writeback does not use the port.
- Queued results are squashed when a younger pipeline write targets the same register.
- A starvation guard stalls writeback for one cycle so the oldest queued result can drain.
- Sits between the writeback stage and the register file.

## Interface
Parameters:
- DEPTH, 4, auxiliary FIFO entries; power of two, ≥2.
- STARVE_LIMIT, 8, cycles a valid FIFO head may wait before writeback is stalled; ≥1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- pipe_we_w  input  1  writeback stage write enable.
- pipe_wa_w  input  5  writeback destination register.
- pipe_wd_w  input  32  writeback data.
- aux_valid  input  1  auxiliary result offered.
- aux_wa  input  5  auxiliary destination register.
- aux_wd  input  32  auxiliary data.
- aux_ready  output  1  FIFO can accept an entry this cycle.
- stall_w  output  1  writeback must hold its inputs this cycle; the arbiter ignores them.
- rf_we  output  1  register-file write enable.
- rf_wa  output  5  register-file write address.
- rf_wd  output  32  register-file write data.

## Operation
- pipe_req = pipe_we_w & (pipe_wa_w != 0) & ~stall_w.
- FIFO entry fields: valid bit, wa, wd. "count" is occupancy, including squashed slots.

Push:
- Occurs when aux_valid & aux_ready.
- aux_ready = (count < DEPTH) & ~reset. It does not depend on a same-cycle pop; there is no pass-through.
- If aux_wa == 0, the push is accepted and the entry is dropped, not stored.

Grant, combinational, priority order:
1. pipe_req: rf_we=1, rf_wa/rf_wd=pipe_wa_w/pipe_wd_w.
2. Else, if the head is present and valid: write the head and pop it.
3. Else: rf_we=0.
- When rf_we=0, rf_wa and rf_wd drive 0.
- A present but squashed head is popped in any cycle, including pipe-grant cycles, with no write.

Squash:
- On a pipe grant to address A, every entry stored at the start of the cycle with wa==A has its valid bit cleared.
- An entry pushed in the same cycle is never squashed.

Starvation counter (cnt, 0..STARVE_LIMIT):
- Reset to 0 when the FIFO is empty, or on any pop.
- Otherwise increments by 1 per cycle while the head is valid and not popped; saturates.
- stall_w = (cnt == STARVE_LIMIT).
- In a stall cycle pipe_req=0, so the head is written and popped and cnt returns to 0.
- Consequence: stall_w is never high in two consecutive cycles.

Simultaneous push and pop: count is unchanged.

Reset, mid-operation included:
- FIFO is emptied, so all queued results are lost.
- cnt is cleared.
- Outputs during reset: stall_w=0, rf_we=0, aux_ready=0.

## Timing
- rf_* and stall_w are combinational from the current inputs and registered state. The register file samples them at the next edge.
- Auxiliary latency is push edge to rf write, at minimum 1 cycle: an entry pushed at edge N can be written in cycle N+1.
- Worst-case wait for a valid head is STARVE_LIMIT cycles of pipe writes, then 1 stall cycle.
- aux_ready first goes high on the first cycle after reset deasserts.

## Configuration
- Macro: RF_ARB_STARVE_GUARD_EN.
- Defined: starvation counter and stall_w behave as specified above.
- Undefined:
  - No counter is built and stall_w is tied 0.
  - Auxiliary entries drain only in cycles with no pipe_req, and may wait indefinitely.
  - All other behaviour is identical.

## Test plan
1. Reset, then aux push wa=3 wd=0x11 with pipe idle -> next cycle rf_we=1, rf_wa=3, rf_wd=0x11; aux_ready stays 1.
2. Fill the FIFO with 4 pushes while the pipe writes r1 every cycle -> aux_ready=0 after the 4th push. With guard enabled, stall_w=1 in the 9th cycle after the first entry becomes head, writing that entry; pipe data is not written that cycle.
3. Queue wa=5 wd=0xAA; in the next cycle the pipe writes r5=0xBB -> rf writes 0xBB once; the queued entry is popped later with rf_we=0; r5 final value 0xBB.
4. Push wa=0 wd=0xFF -> no FIFO occupancy change and no rf write.
5. Assert reset with 3 entries queued, then release -> rf_we=0, aux_ready=0 during reset; the FIFO is empty afterwards and no stale entries are written.
6. Guard macro undefined, pipe writes every cycle for 20 cycles with one entry queued -> stall_w stays 0 and the entry is written in the first pipe-idle cycle.
